tbird_lamp_sequencer: RTL

Parametrised tail-lamp sequencer for the Thunderbird lighting controller. It drives LAMPS lamps per side with sequential left and right turn indication, hazard flashing, and brake override. A built-in prescaler sets the animation step rate. The block sits between the driver-control inputs, which arrive already synchronised to clk, and the lamp driver outputs.

---
 rtl/tbird_lamp_sequencer_if.sv | 23 ++
 rtl/tbird_lamp_sequencer.sv | 101 ++++++++++
 2 files changed

// File: rtl/tbird_lamp_sequencer_if.sv
// Driver-control requests and lamp drive outputs of the tail-lamp sequencer.
interface tbird_lamp_sequencer_if #(
  parameter int LAMPS = 3
);
  logic             left;
  logic             right;
  logic             hazard;
  logic             brake;
  logic [LAMPS-1:0] lamps_l;
  logic [LAMPS-1:0] lamps_r;
  logic             busy;
  logic             step;

  modport master (
    output left, right, hazard, brake,
    input  lamps_l, lamps_r, busy, step
  );

  modport slave (
    input  left, right, hazard, brake,
    output lamps_l, lamps_r, busy, step
  );
endinterface

// File: rtl/tbird_lamp_sequencer.sv
// Thunderbird tail-lamp sequencer: sequential turn, hazard flash and brake override
// with a built-in step prescaler.
module tbird_lamp_sequencer #(
  parameter int LAMPS = 3,
  parameter int DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  tbird_lamp_sequencer_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(LAMPS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(LAMPS);

  typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx, idx_nx;
  logic [LAMPS-1:0] therm, lamps_l_q, lamps_r_q, lamps_l_nx, lamps_r_nx;
  logic             busy_q, step, hz_req;

  assign step   = (cnt == CNT_LAST);
  assign hz_req = bus.hazard | (bus.left & bus.right);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (step) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (step) begin
      unique case (state)
        IDLE: begin
          if (hz_req)         begin state_nx = HAZ_ON; idx_nx = '0;   end
          else if (bus.left)  begin state_nx = LEFT;   idx_nx = IW'(1); end
          else if (bus.right) begin state_nx = RIGHT;  idx_nx = IW'(1); end
        end
        LEFT, RIGHT: begin
          if (hz_req)                begin state_nx = HAZ_ON; idx_nx = '0; end
          else if (idx == IDX_LAST)  begin state_nx = IDLE;   idx_nx = '0; end
          else                       idx_nx = idx + 1'b1;
        end
        HAZ_ON:  state_nx = HAZ_OFF;
        HAZ_OFF: state_nx = hz_req ? HAZ_ON : IDLE;
        default: begin state_nx = IDLE; idx_nx = '0; end
      endcase
    end
  end

  // Frames are built from the next state so a new frame appears right after its step edge,
  // while brake is folded in every cycle.
  always_comb begin
    therm = '0;
    for (int unsigned i = 0; i < LAMPS; i++) therm[i] = (i < 32'(idx_nx));
  end

  always_comb begin
    lamps_l_nx = '0;
    lamps_r_nx = '0;
    unique case (state_nx)
      IDLE: if (bus.brake) begin lamps_l_nx = '1; lamps_r_nx = '1; end
      LEFT: begin
        lamps_l_nx = therm;
        if (bus.brake) lamps_r_nx = '1;
      end
      RIGHT: begin
        lamps_r_nx = therm;
        if (bus.brake) lamps_l_nx = '1;
      end
      HAZ_ON:  begin lamps_l_nx = '1; lamps_r_nx = '1; end
      HAZ_OFF: begin lamps_l_nx = '0; lamps_r_nx = '0; end
      default: begin lamps_l_nx = '0; lamps_r_nx = '0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      lamps_l_q <= '0;
      lamps_r_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      lamps_l_q <= lamps_l_nx;
      lamps_r_q <= lamps_r_nx;
      busy_q    <= (state_nx != IDLE);
    end
  end

  assign bus.lamps_l = lamps_l_q;
  assign bus.lamps_r = lamps_r_q;
  assign bus.busy    = busy_q;
  assign bus.step    = step;
endmodule
